// File: rtl/clock_enable_nco.sv
// Multi-channel NCO clock-enable generator: one phase accumulator per channel, registered
// one-cycle enables, 50% half-rate strobes and a period-aligned turbo multiplier on channel 0.

module clock_enable_nco_lane #(
    parameter int               ACC_W   = 24,
    parameter logic [ACC_W-1:0] INC_RST = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc_wr,
    input  logic [ACC_W-1:0] inc_data,
    input  logic             run,
    input  logic             resync,
    input  logic [1:0]       shift,
    output logic             fire,
    output logic             ce,
    output logic             ce_div2
);
    localparam int EXT_W = ACC_W + 3;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [EXT_W-1:0] inc_eff;
    logic             sat;
    logic [ACC_W:0]   sum;

    assign inc_eff = {3'b000, inc} << shift;
    assign sat     = |inc_eff[EXT_W-1:ACC_W];
    assign sum     = {1'b0, acc} + {1'b0, inc_eff[ACC_W-1:0]};
    // Next-cycle value of ce; lets the turbo switch land on the same edge as the carry.
    assign fire    = !resync && run && (sat || sum[ACC_W]);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            inc     <= INC_RST;
            ce      <= 1'b0;
            ce_div2 <= 1'b0;
        end else begin
            if (inc_wr)
                inc <= inc_data;
            if (resync) begin
                acc     <= '0;
                ce      <= 1'b0;
                ce_div2 <= 1'b0;
            end else if (!run) begin
                ce <= 1'b0;
            end else if (sat) begin
                ce      <= 1'b1;
                ce_div2 <= ~ce_div2;
            end else begin
                acc <= sum[ACC_W-1:0];
                ce  <= sum[ACC_W];
                if (sum[ACC_W])
                    ce_div2 <= ~ce_div2;
            end
        end
    end
endmodule

module clock_enable_nco #(
    parameter int                        CHANNELS = 3,
    parameter int                        ACC_W    = 24,
    parameter logic [CHANNELS*ACC_W-1:0] INC_DEF  = {24'h100000, 24'h200000, 24'h400000}
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] inc_wr,
    input  logic [ACC_W-1:0]    inc_data,
    input  logic [CHANNELS-1:0] run,
    input  logic                resync,
    input  logic [1:0]          turbo,
    output logic [CHANNELS-1:0] ce,
    output logic [CHANNELS-1:0] ce_div2,
    output logic [1:0]          turbo_active
);
    typedef enum logic {STEADY, PENDING} turbo_state_t;

    localparam logic [CHANNELS-1:0] CH0 = CHANNELS'(1);

    turbo_state_t        state;
    logic [CHANNELS-1:0] fire;
    logic                boundary;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        clock_enable_nco_lane #(
            .ACC_W   (ACC_W),
            .INC_RST (INC_DEF[i*ACC_W +: ACC_W])
        ) u_lane (
            .clock    (clock),
            .reset_n  (reset_n),
            .inc_wr   (inc_wr[i]),
            .inc_data (inc_data),
            .run      (run[i]),
            .resync   (resync),
            .shift    ((i == 0) ? turbo_active : 2'b00),
            .fire     (fire[i]),
            .ce       (ce[i]),
            .ce_div2  (ce_div2[i])
        );
    end

    // Channel-0 period boundary, or a point where its phase is frozen/discarded anyway.
    assign boundary = (|(fire & CH0)) || !run[0] || resync;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= STEADY;
            turbo_active <= 2'b00;
        end else begin
            case (state)
                STEADY:
                    if (turbo != turbo_active)
                        state <= PENDING;
                PENDING:
                    if (turbo == turbo_active) begin
                        state <= STEADY;
                    end else if (boundary) begin
                        turbo_active <= turbo;
                        state        <= STEADY;
                    end
                default:
                    state <= STEADY;
            endcase
        end
    end
endmodule

// File: tb/tb_clock_enable_nco.sv
// Directed bench for clock_enable_nco: per-cycle comparison against a rate/phase model
// plus hand-computed pulse timing for the defaults, fractional, turbo, resync and reset cases.

module tb_clock_enable_nco;
    localparam int     CH    = 3;
    localparam int     ACC_W = 24;
    localparam longint MOD   = longint'(1) << ACC_W;

    logic            clock   = 1'b0;
    logic            clk_en  = 1'b1;
    logic            reset_n = 1'b0;
    logic [CH-1:0]   inc_wr  = '0;
    logic [ACC_W-1:0] inc_data = '0;
    logic [CH-1:0]   run     = '0;
    logic            resync  = 1'b0;
    logic [1:0]      turbo   = 2'b00;
    logic [CH-1:0]   ce;
    logic [CH-1:0]   ce_div2;
    logic [1:0]      turbo_active;

    int checks   = 0;
    int failures = 0;

    clock_enable_nco dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .inc_wr       (inc_wr),
        .inc_data     (inc_data),
        .run          (run),
        .resync       (resync),
        .turbo        (turbo),
        .ce           (ce),
        .ce_div2      (ce_div2),
        .turbo_active (turbo_active)
    );

    initial forever begin
        #5;
        if (clk_en) clock = ~clock;
    end

    task automatic expect_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic longint def_inc(input int i);
        case (i)
            0:       return 64'h400000;
            1:       return 64'h200000;
            default: return 64'h100000;
        endcase
    endfunction

    longint        m_acc [CH];
    longint        m_inc [CH];
    logic [CH-1:0] m_ce;
    logic [CH-1:0] m_div2;
    logic [1:0]    m_ta;
    logic          m_pend;
    logic [CH-1:0] n_ce;
    logic [CH-1:0] n_div2;
    longint        rate;
    longint        nxt;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CH; i++) begin
                m_acc[i] <= 0;
                m_inc[i] <= def_inc(i);
            end
            m_ce   <= '0;
            m_div2 <= '0;
            m_ta   <= 2'b00;
            m_pend <= 1'b0;
        end else begin
            n_ce   = m_ce;
            n_div2 = m_div2;
            for (int i = 0; i < CH; i++) begin
                rate = m_inc[i] * ((i == 0) ? (longint'(1) << m_ta) : longint'(1));
                if (resync) begin
                    m_acc[i] <= 0;
                    n_ce[i]   = 1'b0;
                    n_div2[i] = 1'b0;
                end else if (!run[i]) begin
                    n_ce[i] = 1'b0;
                end else if (rate >= MOD) begin
                    n_ce[i]   = 1'b1;
                    n_div2[i] = ~m_div2[i];
                end else begin
                    nxt      = m_acc[i] + rate;
                    n_ce[i]  = (nxt >= MOD);
                    m_acc[i] <= nxt % MOD;
                    if (n_ce[i]) n_div2[i] = ~m_div2[i];
                end
                if (inc_wr[i]) m_inc[i] <= longint'(inc_data);
            end
            m_ce   <= n_ce;
            m_div2 <= n_div2;
            if (!m_pend) begin
                m_pend <= (turbo != m_ta);
            end else if (turbo == m_ta) begin
                m_pend <= 1'b0;
            end else if (n_ce[0] || !run[0] || resync) begin
                m_ta   <= turbo;
                m_pend <= 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        if (reset_n) begin
            expect_int("model_ce", int'(ce), int'(m_ce));
            expect_int("model_ce_div2", int'(ce_div2), int'(m_div2));
            expect_int("model_turbo_active", int'(turbo_active), int'(m_ta));
        end
    end

    // ---------------- measurement helpers ----------------
    int p_first [CH];
    int p_cnt   [CH];
    int p_gmin  [CH];
    int p_gmax  [CH];
    int d_high  [CH];
    int d_tog   [CH];
    int diff12;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Index k counts posedges from the call; samples are taken on the following negedge.
    task automatic measure(input int n);
        int            last [CH];
        logic [CH-1:0] pd;
        pd     = ce_div2;
        diff12 = 0;
        for (int c = 0; c < CH; c++) begin
            last[c] = -1; p_first[c] = -1; p_cnt[c] = 0;
            p_gmin[c] = 1 << 30; p_gmax[c] = 0; d_high[c] = 0; d_tog[c] = 0;
        end
        for (int k = 1; k <= n; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (ce[1] != ce[2]) diff12++;
            for (int c = 0; c < CH; c++) begin
                if (ce[c]) begin
                    if (p_first[c] < 0) p_first[c] = k;
                    if (last[c] >= 0) begin
                        if (k - last[c] < p_gmin[c]) p_gmin[c] = k - last[c];
                        if (k - last[c] > p_gmax[c]) p_gmax[c] = k - last[c];
                    end
                    last[c] = k;
                    p_cnt[c]++;
                end
                if (ce_div2[c]) d_high[c]++;
                if (ce_div2[c] != pd[c]) d_tog[c]++;
            end
            pd = ce_div2;
        end
    endtask

    task automatic check_defaults(input string tag);
        measure(40);
        expect_int({tag, "_ch0_first"}, p_first[0], 4);
        expect_int({tag, "_ch0_gap_min"}, p_gmin[0], 4);
        expect_int({tag, "_ch0_gap_max"}, p_gmax[0], 4);
        expect_int({tag, "_ch0_count"}, p_cnt[0], 10);
        expect_int({tag, "_ch1_first"}, p_first[1], 8);
        expect_int({tag, "_ch1_gap"}, p_gmax[1], 8);
        expect_int({tag, "_ch2_first"}, p_first[2], 16);
        expect_int({tag, "_ch2_gap"}, p_gmax[2], 16);
        expect_int({tag, "_div2_high"}, d_high[0], 20);
        expect_int({tag, "_div2_toggles"}, d_tog[0], 10);
    endtask

    int ta_k, ce_at_switch, nxt_k;

    initial begin
        // 1: reset state and default rates
        repeat (3) step();
        expect_int("reset_ce", int'(ce), 0);
        expect_int("reset_ce_div2", int'(ce_div2), 0);
        expect_int("reset_turbo_active", int'(turbo_active), 0);
        run     = 3'b111;
        reset_n = 1'b1;
        check_defaults("t1");

        // 2: fractional 1/3 rate from a clean phase
        step();
        inc_wr = 3'b001; inc_data = 24'h555556; resync = 1'b1;
        step();
        inc_wr = '0; resync = 1'b0;
        measure(3000);
        expect_int("t2_count", p_cnt[0], 1000);
        expect_int("t2_first", p_first[0], 3);
        expect_int("t2_gap_min", p_gmin[0], 3);
        expect_int("t2_gap_max", p_gmax[0], 3);

        // 3: turbo x2 requested mid-period takes effect on the next ch-0 carry
        step();
        inc_wr = 3'b001; inc_data = 24'h100000; resync = 1'b1;
        step();
        inc_wr = '0; resync = 1'b0;
        measure(20);
        expect_int("t3_first", p_first[0], 16);
        step();
        turbo = 2'b01;
        ta_k = -1; ce_at_switch = 0; nxt_k = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (ta_k < 0 && turbo_active == 2'b01) begin
                ta_k = k;
                ce_at_switch = int'(ce[0]);
            end else if (ta_k > 0 && nxt_k < 0 && ce[0]) begin
                nxt_k = k;
            end
        end
        expect_int("t3_switch_cycle", ta_k, 11);
        expect_int("t3_ce_at_switch", ce_at_switch, 1);
        expect_int("t3_gap_after_switch", nxt_k - ta_k, 8);

        // 4: x8 saturates channel 0
        step();
        inc_wr = 3'b001; inc_data = 24'h400000; turbo = 2'b11;
        step();
        inc_wr = '0;
        repeat (6) step();
        measure(16);
        expect_int("t4_turbo_active", int'(turbo_active), 3);
        expect_int("t4_ce_count", p_cnt[0], 16);
        expect_int("t4_div2_toggles", d_tog[0], 16);

        // 5: resync realigns channels with equal rates
        step();
        inc_wr = 3'b110; inc_data = 24'h200000;
        step();
        inc_wr = '0; run = 3'b011;
        repeat (3) step();
        run = 3'b111;
        repeat (5) step();
        resync = 1'b1;
        step();
        resync = 1'b0;
        expect_int("t5_ce_after_resync", int'(ce), 0);
        expect_int("t5_div2_after_resync", int'(ce_div2), 0);
        measure(32);
        expect_int("t5_ch1_count", p_cnt[1], 4);
        expect_int("t5_ch2_first", p_first[2], 8);
        expect_int("t5_ch1_ch2_diff", diff12, 0);

        // 6: async reset with the clock stopped, then default timing again
        repeat (5) step();
        @(negedge clock);
        clk_en = 1'b0;
        #2;
        expect_int("t6_ta_before_reset", int'(turbo_active), 3);
        turbo   = 2'b00;
        reset_n = 1'b0;
        #3;
        expect_int("t6_ce_async", int'(ce), 0);
        expect_int("t6_div2_async", int'(ce_div2), 0);
        expect_int("t6_ta_async", int'(turbo_active), 0);
        #10;
        clk_en = 1'b1;
        repeat (2) step();
        reset_n = 1'b1;
        check_defaults("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
